// File: rtl/toothless_pkg.sv
// Shared LSU/decoder definitions: FSM states, data-type encodings and the
// lane helpers that turn a (type, offset) pair into byte enables and
// replicated store data.
package toothless_pkg;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_WAIT_GNT,
    LSU_WAIT_RVALID
  } lsu_state_e;

  localparam logic [1:0] DATA_TYPE_BYTE = 2'b00;
  localparam logic [1:0] DATA_TYPE_HALF = 2'b01;
  localparam logic [1:0] DATA_TYPE_WORD = 2'b10;

  // Half-words must be 2-byte aligned, words 4-byte aligned; type 11 is a word.
  function automatic logic is_misaligned(input logic [1:0] dtype, input logic [1:0] offset);
    case (dtype)
      DATA_TYPE_BYTE: is_misaligned = 1'b0;
      DATA_TYPE_HALF: is_misaligned = offset[0];
      default:        is_misaligned = (offset != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] byte_enable(input logic [1:0] dtype, input logic [1:0] offset);
    case (dtype)
      DATA_TYPE_BYTE: byte_enable = 4'b0001 << offset;
      DATA_TYPE_HALF: byte_enable = 4'b0011 << {offset[1], 1'b0};
      default:        byte_enable = 4'b1111;
    endcase
  endfunction

  // Replicate the store operand into every lane so the memory picks the
  // right one purely from the byte enables.
  function automatic logic [31:0] replicate_wdata(input logic [1:0] dtype, input logic [31:0] wdata);
    case (dtype)
      DATA_TYPE_BYTE: replicate_wdata = {4{wdata[7:0]}};
      DATA_TYPE_HALF: replicate_wdata = {2{wdata[15:0]}};
      default:        replicate_wdata = wdata;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load-data alignment: shifts the addressed bytes down to
// bit 0 and sign- or zero-extends sub-word loads.
module lsu_load_align
  import toothless_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] i_rdata,
  input  logic [1:0]            i_offset,
  input  logic [1:0]            i_type,
  input  logic                  i_sign,
  output logic [DATA_WIDTH-1:0] o_result
);

  logic [DATA_WIDTH-1:0] w_shifted;

  assign w_shifted = i_rdata >> {i_offset, 3'b000};

  // Select and extend the addressed byte/half; words pass through (offset is 0).
  always_comb begin
    // NOTE: default assignment first so every path drives o_result and no latch is inferred.
    o_result = w_shifted;
    case (i_type)
      DATA_TYPE_BYTE: o_result = {{(DATA_WIDTH-8){i_sign & w_shifted[7]}}, w_shifted[7:0]};
      DATA_TYPE_HALF: o_result = {{(DATA_WIDTH-16){i_sign & w_shifted[15]}}, w_shifted[15:0]};
      default:        o_result = w_shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: accepts one core access at a time, runs a
// req/gnt/rvalid transaction on the data port and returns extended load data.
module load_store_unit
  import toothless_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  data_req_i,
  input  logic                  data_we_i,
  input  logic [1:0]            data_type_i,
  input  logic                  data_sign_ext_i,
  input  logic [DATA_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  busy_o,
  output logic                  rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  err_o,
  output logic                  misaligned_o,
  output logic                  mem_req_o,
  input  logic                  mem_gnt_i,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_err_i
);

  lsu_state_e            r_state;
  logic [1:0]            r_offset;
  logic [1:0]            r_type;
  logic                  r_sign;
  logic                  w_misaligned;
  logic [DATA_WIDTH-1:0] w_load_data;

  assign w_misaligned = is_misaligned(data_type_i, addr_i[1:0]);

  lsu_load_align #(.DATA_WIDTH(DATA_WIDTH)) u_load_align (
    .i_rdata  (mem_rdata_i),
    .i_offset (r_offset),
    .i_type   (r_type),
    .i_sign   (r_sign),
    .o_result (w_load_data)
  );

  // Transaction FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
      r_state      <= LSU_IDLE;
      r_offset     <= '0;
      r_type       <= '0;
      r_sign       <= 1'b0;
      busy_o       <= 1'b0;
      rvalid_o     <= 1'b0;
      rdata_o      <= '0;
      err_o        <= 1'b0;
      misaligned_o <= 1'b0;
      mem_req_o    <= 1'b0;
      mem_addr_o   <= '0;
      mem_we_o     <= 1'b0;
      mem_be_o     <= '0;
      mem_wdata_o  <= '0;
    end else begin
      // Status outputs are single-cycle pulses unless re-asserted below.
      rvalid_o     <= 1'b0;
      err_o        <= 1'b0;
      misaligned_o <= 1'b0;
      case (r_state)
        LSU_IDLE: begin
          if (data_req_i) begin
            if (w_misaligned) begin
              misaligned_o <= 1'b1;
            end else begin
              r_state     <= LSU_WAIT_GNT;
              busy_o      <= 1'b1;
              mem_req_o   <= 1'b1;
              mem_addr_o  <= {addr_i[DATA_WIDTH-1:2], 2'b00};
              mem_we_o    <= data_we_i;
              // Loads read the whole word, so byte enables only qualify stores.
              mem_be_o    <= data_we_i ? byte_enable(data_type_i, addr_i[1:0]) : 4'b0000;
              mem_wdata_o <= replicate_wdata(data_type_i, wdata_i);
              r_offset    <= addr_i[1:0];
              r_type      <= data_type_i;
              r_sign      <= data_sign_ext_i;
            end
          end
        end
        LSU_WAIT_GNT: begin
          // A simultaneous rvalid is a protocol violation and is dropped.
          if (mem_gnt_i) begin
            mem_req_o <= 1'b0;
            r_state   <= LSU_WAIT_RVALID;
          end
        end
        LSU_WAIT_RVALID: begin
          if (mem_rvalid_i) begin
            r_state  <= LSU_IDLE;
            busy_o   <= 1'b0;
            rvalid_o <= 1'b1;
            if (mem_err_i) begin
              err_o   <= 1'b1;
              rdata_o <= '0;
            end else if (!mem_we_o) begin
              rdata_o <= w_load_data;
            end
          end
        end
        default: r_state <= LSU_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stimulus pushes expected responses
// into a scoreboard queue, a negedge monitor pops them on rvalid_o.
module tb_load_store_unit;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  logic        clk;
  logic        rst_n;
  logic        data_req_i;
  logic        data_we_i;
  logic [1:0]  data_type_i;
  logic        data_sign_ext_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        busy_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        misaligned_o;
  logic        mem_req_o;
  logic        mem_gnt_i;
  logic [31:0] mem_addr_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        mem_err_i;

  int    n_checks = 0;
  int    n_errors = 0;
  resp_t exp_q[$];
  logic [31:0] last_rdata;

  load_store_unit #(.DATA_WIDTH(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .data_req_i      (data_req_i),
    .data_we_i       (data_we_i),
    .data_type_i     (data_type_i),
    .data_sign_ext_i (data_sign_ext_i),
    .addr_i          (addr_i),
    .wdata_i         (wdata_i),
    .busy_o          (busy_o),
    .rvalid_o        (rvalid_o),
    .rdata_o         (rdata_o),
    .err_o           (err_o),
    .misaligned_o    (misaligned_o),
    .mem_req_o       (mem_req_o),
    .mem_gnt_i       (mem_gnt_i),
    .mem_addr_o      (mem_addr_o),
    .mem_we_o        (mem_we_o),
    .mem_be_o        (mem_be_o),
    .mem_wdata_o     (mem_wdata_o),
    .mem_rvalid_i    (mem_rvalid_i),
    .mem_rdata_i     (mem_rdata_i),
    .mem_err_i       (mem_err_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Scoreboard monitor: every completion must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && rvalid_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rvalid", 32'(rvalid_o), 32'd0);
      end else begin
        resp_t e;
        e = exp_q.pop_front();
        check("sb_rdata", rdata_o, e.rdata);
        check("sb_err", 32'(err_o), 32'(e.err));
      end
    end
  end

  // One complete aligned transaction with a grant delay and a chosen response.
  task automatic do_txn(input string name, input logic we, input logic [1:0] dtype,
                        input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                        input int gnt_delay, input logic [31:0] resp_data, input logic resp_err,
                        input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                        input logic [31:0] exp_rdata);
    resp_t e;
    e.err   = resp_err;
    e.rdata = resp_err ? 32'h0 : (we ? last_rdata : exp_rdata);
    last_rdata = e.rdata;
    exp_q.push_back(e);
    // Cycle N: present the request.
    data_req_i = 1'b1; data_we_i = we; data_type_i = dtype; data_sign_ext_i = sgn;
    addr_i = addr; wdata_i = wdata;
    @(posedge clk); #1;
    data_req_i = 1'b0;
    // Cycles N+1 .. N+1+gnt_delay: request held stable, stray requests ignored.
    for (int i = 0; i <= gnt_delay; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      mem_gnt_i  = (i == gnt_delay);
      data_req_i = (i < gnt_delay);
      data_we_i  = 1'b1;
      data_type_i = 2'b10;
      addr_i     = 32'hDEAD_0004;
      wdata_i    = 32'h1111_2222;
      @(negedge clk);
      check({name, "_mem_req"}, 32'(mem_req_o), 32'd1);
      check({name, "_busy"}, 32'(busy_o), 32'd1);
      check({name, "_mem_addr"}, mem_addr_o, {addr[31:2], 2'b00});
      check({name, "_mem_we"}, 32'(mem_we_o), 32'(we));
      check({name, "_mem_be"}, 32'(mem_be_o), 32'(exp_be));
      check({name, "_mem_wdata"}, mem_wdata_o, exp_wdata);
    end
    // Cycle N+2+gnt_delay: request dropped, memory responds.
    @(posedge clk); #1;
    mem_gnt_i = 1'b0; data_req_i = 1'b0;
    mem_rvalid_i = 1'b1; mem_rdata_i = resp_data; mem_err_i = resp_err;
    @(negedge clk);
    check({name, "_req_dropped"}, 32'(mem_req_o), 32'd0);
    check({name, "_busy_wait"}, 32'(busy_o), 32'd1);
    // Completion cycle.
    @(posedge clk); #1;
    mem_rvalid_i = 1'b0; mem_err_i = 1'b0; mem_rdata_i = 32'h5A5A_5A5A;
    @(negedge clk);
    check({name, "_rvalid"}, 32'(rvalid_o), 32'd1);
    check({name, "_busy_done"}, 32'(busy_o), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check({name, "_rvalid_pulse"}, 32'(rvalid_o), 32'd0);
    check({name, "_no_stray_txn"}, 32'(busy_o), 32'd0);
  endtask

  task automatic do_misaligned(input string name, input logic [1:0] dtype, input logic [31:0] addr);
    data_req_i = 1'b1; data_we_i = 1'b0; data_type_i = dtype; data_sign_ext_i = 1'b0;
    addr_i = addr; wdata_i = 32'h0;
    @(posedge clk); #1;
    data_req_i = 1'b0;
    @(negedge clk);
    check({name, "_misaligned"}, 32'(misaligned_o), 32'd1);
    check({name, "_no_req"}, 32'(mem_req_o), 32'd0);
    check({name, "_no_busy"}, 32'(busy_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check({name, "_mis_pulse"}, 32'(misaligned_o), 32'd0);
      check({name, "_quiet"}, {29'd0, mem_req_o, busy_o, rvalid_o}, 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0; data_req_i = 1'b0; data_we_i = 1'b0; data_type_i = 2'b00;
    data_sign_ext_i = 1'b0; addr_i = '0; wdata_i = '0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0; mem_err_i = 1'b0;
    last_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_ctrl", {26'd0, busy_o, rvalid_o, err_o, misaligned_o, mem_req_o, mem_we_o}, 32'd0);
    check("reset_be", 32'(mem_be_o), 32'd0);
    check("reset_addr", mem_addr_o, 32'd0);
    check("reset_wdata", mem_wdata_o, 32'd0);
    check("reset_rdata", rdata_o, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // name, we, type, sign, addr, wdata, gnt_delay, resp, err, be, wdata_lanes, rdata
    do_txn("lb_s",  1'b0, 2'b00, 1'b1, 32'h0000_1003, 32'h0, 0, 32'h8000_0000, 1'b0, 4'b0000, 32'h0, 32'hFFFF_FF80);
    do_txn("lbu",   1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0, 0, 32'h8000_0000, 1'b0, 4'b0000, 32'h0, 32'h0000_0080);
    do_txn("sh",    1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h0000_BEEF, 0, 32'h0, 1'b0, 4'b1100, 32'hBEEF_BEEF, 32'h0);
    do_misaligned("lw_mis", 2'b10, 32'h0000_3001);
    do_txn("lh_gnt5", 1'b0, 2'b01, 1'b1, 32'h0000_3002, 32'h0, 5, 32'h8123_4567, 1'b0, 4'b0000, 32'h0, 32'hFFFF_8123);
    do_txn("sb",    1'b1, 2'b00, 1'b0, 32'h0000_5001, 32'h0000_00A5, 2, 32'h0, 1'b0, 4'b0010, 32'hA5A5_A5A5, 32'h0);
    do_txn("lw_err", 1'b0, 2'b10, 1'b0, 32'h0000_6000, 32'h0, 0, 32'h1234_5678, 1'b1, 4'b0000, 32'h0, 32'h0);
    do_txn("lw_ok", 1'b0, 2'b10, 1'b0, 32'h0000_6004, 32'h0, 1, 32'hCAFE_F00D, 1'b0, 4'b0000, 32'h0, 32'hCAFE_F00D);
    do_txn("lhu",   1'b0, 2'b01, 1'b0, 32'h0000_7002, 32'h0, 0, 32'h89AB_0000, 1'b0, 4'b0000, 32'h0, 32'h0000_89AB);
    do_txn("sw",    1'b1, 2'b11, 1'b0, 32'h0000_7004, 32'h1357_9BDF, 0, 32'h0, 1'b0, 4'b1111, 32'h1357_9BDF, 32'h0);
    do_misaligned("lh_mis", 2'b01, 32'h0000_7001);

    // Reset while waiting for rvalid: response is dropped.
    data_req_i = 1'b1; data_we_i = 1'b0; data_type_i = 2'b10; data_sign_ext_i = 1'b0;
    addr_i = 32'h0000_4000;
    @(posedge clk); #1;
    data_req_i = 1'b0; mem_gnt_i = 1'b1;
    @(posedge clk); #1;
    mem_gnt_i = 1'b0;
    @(negedge clk);
    check("rst_pre_busy", 32'(busy_o), 32'd1);
    check("rst_pre_req", 32'(mem_req_o), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hFEED_FACE;
    @(negedge clk);
    check("rst_mid_ctrl", {26'd0, busy_o, rvalid_o, err_o, misaligned_o, mem_req_o, mem_we_o}, 32'd0);
    check("rst_mid_addr", mem_addr_o, 32'd0);
    check("rst_mid_rdata", rdata_o, 32'd0);
    @(posedge clk); #1;
    mem_rvalid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_late_rvalid", 32'(rvalid_o), 32'd0);
      check("rst_rdata_hold", rdata_o, 32'd0);
      @(posedge clk); #1;
    end

    // Drain: every expected response must have been observed.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
